// File: rtl/final_top_ctrl.sv
`default_nettype none
// ============================================================================
// final_top_ctrl : 8N1 UART command interpreter driving one bidirectional GPIO
// Revision 1.0
// ============================================================================
module final_top_ctrl #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic SYSCLK,
  input  logic MSS_RESET_N,
  input  logic UART_0_RXD,
  output logic UART_0_TXD,
  inout  wire  GPIO_0_BI
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic            rx_meta_q, rx_sync_q, gp_meta_q, gp_sync_q;
  logic            armed_q, armed_d;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_valid, frame_err;

  logic            gpio_out_q, gpio_out_d, gpio_oe_q, gpio_oe_d;
  logic [7:0]      reply;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;

  tx_state_t       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            txd_q, txd_d;
  logic            tx_load;

  // Receiver: start qualified by the armed flag so a held-low line yields one error only
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (armed_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        rx_valid   = rx_sync_q;
        frame_err  = !rx_sync_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
    armed_d = frame_err ? 1'b0 : (rx_sync_q ? 1'b1 : armed_q);
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    gpio_oe_d  = gpio_oe_q;
    reply      = 8'h21;
    if (rx_valid) begin
      case (rx_sh_q)
        8'h31: begin gpio_out_d = 1'b1; gpio_oe_d = 1'b1; reply = 8'h4B; end
        8'h30: begin gpio_out_d = 1'b0; gpio_oe_d = 1'b1; reply = 8'h4B; end
        8'h5A: begin gpio_oe_d = 1'b0; reply = 8'h4B; end
        8'h3F: reply = gp_sync_q ? 8'h31 : 8'h30;
        default: reply = 8'h21;
      endcase
    end
  end

  // Transmitter: a pending reply is taken at the end of the stop bit so frames abut
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_load  = hold_full_q;
      end
      TX_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        txd_d      = tx_sh_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          txd_d      = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          txd_d    = tx_sh_q[1];
          tx_bit_d = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
        tx_load    = hold_full_q;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_sh_d    = hold_q;
      txd_d      = 1'b0;
      tx_cnt_d   = '0;
      tx_state_d = TX_START;
    end
    hold_d      = hold_q;
    hold_full_d = hold_full_q & ~tx_load;
    if (rx_valid && (!hold_full_q || tx_load)) begin
      hold_d      = reply;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      gp_meta_q   <= 1'b1;
      gp_sync_q   <= 1'b1;
      armed_q     <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      gpio_out_q  <= 1'b0;
      gpio_oe_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_sh_q     <= '0;
      txd_q       <= 1'b1;
    end else begin
      rx_meta_q   <= UART_0_RXD;
      rx_sync_q   <= rx_meta_q;
      gp_meta_q   <= GPIO_0_BI;
      gp_sync_q   <= gp_meta_q;
      armed_q     <= armed_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      gpio_out_q  <= gpio_out_d;
      gpio_oe_q   <= gpio_oe_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      txd_q       <= txd_d;
    end
  end

  assign UART_0_TXD = txd_q;
  assign GPIO_0_BI  = gpio_oe_q ? gpio_out_q : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_final_top_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_final_top_ctrl : randomized self-checking bench with a command-level model
// Revision 1.0
// ============================================================================
module tb_final_top_ctrl;

  localparam int  CPB = 16;
  localparam time T   = 100;
  localparam time BIT = CPB * T;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rxd = 1'b1;
  wire  txd;
  wire  gpio;
  logic ext_en = 1'b0;
  logic ext_val = 1'b0;

  assign gpio = ext_en ? ext_val : 1'bz;
  pullup (gpio);

  final_top_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .SYSCLK      (clk),
    .MSS_RESET_N (rst_n),
    .UART_0_RXD  (rxd),
    .UART_0_TXD  (txd),
    .GPIO_0_BI   (gpio)
  );

  always #(T/2) clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Command-level model of the GPIO pin
  logic m_oe  = 1'b0;
  logic m_out = 1'b0;

  // Reply capture from the serial line
  logic [7:0] rep_q[$];
  time        rep_t[$];
  int         rd_idx = 0;
  int         stop_bad = 0;
  int         txd_falls = 0;
  time        last_fall = 0;
  int         fe_cnt = 0;
  time        rxv_t = 0;

  always @(negedge txd) begin
    txd_falls++;
    last_fall = $time;
  end

  always @(negedge clk) begin
    if (dut.frame_err) fe_cnt++;
    if (dut.rx_valid) rxv_t = $time;
  end

  initial begin
    logic [7:0] b;
    time t0;
    forever begin
      @(negedge txd);
      t0 = $time;
      #(BIT/2);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          #(BIT);
          b[i] = txd;
        end
        #(BIT);
        if (txd !== 1'b1) stop_bad++;
        rep_q.push_back(b);
        rep_t.push_back(t0);
      end
    end
  end

  initial begin
    #(9ms);
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

  function automatic logic pin_exp();
    return m_oe ? m_out : (ext_en ? ext_val : 1'b1);
  endfunction

  task automatic model_cmd(input logic [7:0] c, output logic [7:0] r);
    r = 8'h4B;
    case (c)
      8'h31: begin m_out = 1'b1; m_oe = 1'b1; end
      8'h30: begin m_out = 1'b0; m_oe = 1'b1; end
      8'h5A: m_oe = 1'b0;
      8'h3F: r = pin_exp() ? 8'h31 : 8'h30;
      default: r = 8'h21;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(BIT);
    end
    rxd = stop;
    #(BIT);
    rxd = 1'b1;
  endtask

  task automatic get_reply(output bit ok, output logic [7:0] b, output time t);
    ok = 1'b0;
    b  = 8'hxx;
    t  = 0;
    for (int k = 0; k < 30 * CPB && !ok; k++) begin
      @(negedge clk);
      if (rep_q.size() > rd_idx) begin
        ok = 1'b1;
        b  = rep_q[rd_idx];
        t  = rep_t[rd_idx];
        rd_idx++;
      end
    end
  endtask

  task automatic do_cmd(input string nm, input logic [7:0] c, output time t_rep);
    logic [7:0] exp_r, got;
    bit ok;
    model_cmd(c, exp_r);
    send_byte(c, 1'b1);
    get_reply(ok, got, t_rep);
    n_vec++;
    if (!ok || got !== exp_r) begin
      n_err++;
      $display("FAIL %s reply: got %h (arrived=%0d) expected %h", nm, got, ok, exp_r);
    end
    n_vec++;
    if (gpio !== pin_exp()) begin
      n_err++;
      $display("FAIL %s pin: got %b expected %b", nm, gpio, pin_exp());
    end
  endtask

  task automatic test_reset_break();
    int fe0, falls0;
    rxd = 1'b0;
    #1 rst_n = 1'b0;
    #(998);
    n_vec++;
    if (txd !== 1'b1 || gpio !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: txd=%b pin=%b expected txd=1 pin=1(released)", txd, gpio);
    end
    fe0 = fe_cnt;
    falls0 = txd_falls;
    rd_idx = rep_q.size();
    #1 rst_n = 1'b1;
    repeat (5000) @(negedge clk);
    n_vec++;
    if (fe_cnt - fe0 != 1) begin
      n_err++;
      $display("FAIL break_frame_errors: got %0d expected 1", fe_cnt - fe0);
    end
    n_vec++;
    if (txd_falls != falls0 || rep_q.size() != rd_idx || txd !== 1'b1) begin
      n_err++;
      $display("FAIL break_txd_idle: falls=%0d replies=%0d txd=%b expected 0 0 1",
               txd_falls - falls0, rep_q.size() - rd_idx, txd);
    end
    n_vec++;
    if (gpio !== 1'b1) begin
      n_err++;
      $display("FAIL break_pin: got %b expected 1(released)", gpio);
    end
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
  endtask

  task automatic test_drive_one();
    time t;
    do_cmd("drive_one", 8'h31, t);
    n_vec++;
    if (!(t > rxv_t && t - rxv_t <= 2 * T + T / 2)) begin
      n_err++;
      $display("FAIL reply_latency: got %0t after valid expected <= %0t", t - rxv_t, 2 * T + T / 2);
    end
  endtask

  task automatic test_release_readback();
    time t;
    do_cmd("release", 8'h5A, t);
    ext_en = 1'b1; ext_val = 1'b0;
    #(T);
    do_cmd("readback_low", 8'h3F, t);
    ext_val = 1'b1;
    #(T);
    do_cmd("readback_high", 8'h3F, t);
    ext_en = 1'b0;
    #(T);
  endtask

  task automatic test_unknown();
    time t;
    do_cmd("set_high", 8'h31, t);
    do_cmd("unknown", 8'h41, t);
  endtask

  task automatic test_framing();
    int fe0;
    time t;
    fe0 = fe_cnt;
    send_byte(8'h30, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    n_vec++;
    if (rep_q.size() != rd_idx || fe_cnt - fe0 != 1) begin
      n_err++;
      $display("FAIL framing_drop: replies=%0d errors=%0d expected 0 1", rep_q.size() - rd_idx, fe_cnt - fe0);
    end
    n_vec++;
    if (gpio !== pin_exp()) begin
      n_err++;
      $display("FAIL framing_pin: got %b expected %b", gpio, pin_exp());
    end
    repeat (2 * CPB) @(negedge clk);
    do_cmd("after_framing", 8'h30, t);
  endtask

  task automatic test_random();
    logic [7:0] c;
    time t;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h31;
        1: c = 8'h30;
        2: c = 8'h5A;
        3: c = 8'h3F;
        default: c = 8'($urandom);
      endcase
      if (c == 8'h3F && !m_oe && $urandom_range(0, 1) == 1) begin
        ext_en = 1'b1;
        ext_val = 1'($urandom);
        #(T);
      end
      do_cmd("random", c, t);
      ext_en = 1'b0;
      #(T);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, r, got;
    logic [7:0] exp_q[$];
    bit ok;
    time t;
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 3))
        0: c = 8'h31;
        1: c = 8'h3F;
        2: c = 8'h5A;
        default: c = 8'($urandom);
      endcase
      model_cmd(c, r);
      exp_q.push_back(r);
      send_byte(c, 1'b1);
    end
    foreach (exp_q[i]) begin
      get_reply(ok, got, t);
      n_vec++;
      if (!ok || got !== exp_q[i]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %h (arrived=%0d) expected %h", i, got, ok, exp_q[i]);
      end
    end
    n_vec++;
    if (stop_bad != 0) begin
      n_err++;
      $display("FAIL tx_stop_bits: got %0d bad stop bits expected 0", stop_bad);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] r;
    time t;
    int falls0;
    bit seen;
    falls0 = txd_falls;
    model_cmd(8'h30, r);
    send_byte(8'h30, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 4 * CPB && !seen; k++) begin
      if (txd_falls != falls0) seen = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL midframe_start: got no TX frame expected one");
    end else begin
      // bit 2 of 'K' is a zero, so TXD is low here
      #(last_fall + 3 * BIT + BIT / 2 + 30 - $time);
      n_vec++;
      if (txd !== 1'b0 || gpio !== 1'b0) begin
        n_err++;
        $display("FAIL midframe_pre: txd=%b pin=%b expected 0 0", txd, gpio);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (txd !== 1'b1 || gpio !== 1'b1) begin
        n_err++;
        $display("FAIL async_reset: txd=%b pin=%b expected 1 1(released)", txd, gpio);
      end
    end
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    m_oe = 1'b0;
    m_out = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    rd_idx = rep_q.size();
    do_cmd("post_reset_query", 8'h3F, t);
  endtask

  initial begin
    test_reset_break();
    test_drive_one();
    test_release_readback();
    test_unknown();
    test_framing();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
